// File: rtl/pam_demod.sv
// pam_demod: integrate-and-dump 4-PAM demodulator.
// Integrates SAMPLES_PER_SYM valid samples per symbol, slices the sum into a
// 2-bit symbol and presents it through a one-entry valid/ready register.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/in_data signed sample stream
//   in_sync          first sample of a symbol (qualified by in_valid)
//   sym_valid/ready  output handshake
//   sym_data         decided symbol: 00=-3, 01=-1, 10=+1, 11=+3
//   sym_acc          integrated sum that produced sym_data
//   overrun          sticky: a completed symbol was dropped
//   locked           high while accumulating
module pam_demod #(
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned SAMPLES_PER_SYM = 16,
  parameter int unsigned ACC_W           = 24,
  parameter int unsigned THRESH          = 32768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sync,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic [1:0]        sym_data,
  output logic [ACC_W-1:0]  sym_acc,
  output logic              overrun,
  output logic              locked
);

  localparam int unsigned CNT_W = $clog2(SAMPLES_PER_SYM + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_SYM - 1);
  localparam logic signed [ACC_W-1:0] THR_POS = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] THR_NEG = -THR_POS;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     sym_valid_q, sym_valid_d;
  logic [1:0]               sym_data_q, sym_data_d;
  logic [ACC_W-1:0]         sym_acc_q, sym_acc_d;
  logic                     overrun_q, overrun_d;
  logic                     locked_q, locked_d;

  logic signed [ACC_W-1:0]  in_ext;
  logic signed [ACC_W-1:0]  sum;
  logic [1:0]               slice;
  logic                     complete;

  // Sign-extend the sample and form the running sum (wraps modulo 2^ACC_W)
  always_comb begin
    in_ext = {{(ACC_W - DATA_W){in_data[DATA_W-1]}}, in_data};
    sum    = acc_q + in_ext;
  end

  // Four-level slicer on the completed sum
  always_comb begin
    if (sum >= THR_POS)      slice = 2'b11;
    else if (!sum[ACC_W-1])  slice = 2'b10;
    else if (sum >= THR_NEG) slice = 2'b01;
    else                     slice = 2'b00;
  end

  // Next-state, accumulator and output register logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sym_valid_d = sym_valid_q;
    sym_data_d  = sym_data_q;
    sym_acc_d   = sym_acc_q;
    overrun_d   = overrun_q;
    complete    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_sync) begin
          acc_d   = in_ext;
          cnt_d   = CNT_W'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (in_sync) begin
            // Realign: discard any partial sum
            acc_d = in_ext;
            cnt_d = CNT_W'(1);
          end else if (cnt_q == LAST_CNT) begin
            complete = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Held symbol is kept on collision; the new one is dropped
    if (complete) begin
      if (!sym_valid_q || sym_ready) begin
        sym_valid_d = 1'b1;
        sym_data_d  = slice;
        sym_acc_d   = sum;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (sym_valid_q && sym_ready) begin
      sym_valid_d = 1'b0;
    end

    locked_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_data_q  <= '0;
      sym_acc_q   <= '0;
      overrun_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sym_valid_q <= sym_valid_d;
      sym_data_q  <= sym_data_d;
      sym_acc_q   <= sym_acc_d;
      overrun_q   <= overrun_d;
      locked_q    <= locked_d;
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym_data  = sym_data_q;
  assign sym_acc   = sym_acc_q;
  assign overrun   = overrun_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_pam_demod.sv
// Directed testbench for pam_demod with SAMPLES_PER_SYM=4, THRESH=400.
module tb_pam_demod;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SPS    = 4;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned THR    = 400;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_sync;
  logic              sym_valid;
  logic              sym_ready;
  logic [1:0]        sym_data;
  logic [ACC_W-1:0]  sym_acc;
  logic              overrun;
  logic              locked;

  int vectors    = 0;
  int miscompares = 0;
  int n_acc      = 0;

  pam_demod #(
    .DATA_W(DATA_W), .SAMPLES_PER_SYM(SPS), .ACC_W(ACC_W), .THRESH(THR)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_sync(in_sync),
    .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_data(sym_data), .sym_acc(sym_acc),
    .overrun(overrun), .locked(locked)
  );

  always #5 clk = ~clk;

  // Count output transfers
  always @(posedge clk) begin
    if (!rst && sym_valid && sym_ready) n_acc <= n_acc + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample for one clock, then drop in_valid
  task automatic send(input int d, input logic s);
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    in_sync  = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Send one 4-sample symbol of constant value, optional sync on the first
  task automatic send_sym(input int d, input logic s);
    send(d, s);
    for (int i = 1; i < int'(SPS); i++) send(d, 1'b0);
  endtask

  task automatic check_sym(input string tag, input int acc, input int dat);
    check({tag, ".valid"}, int'(sym_valid), 1);
    check({tag, ".acc"},   int'($signed(sym_acc)), acc);
    check({tag, ".data"},  int'(sym_data), dat);
  endtask

  int base;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sync = 1'b0; sym_ready = 1'b1;

    // 1. Reset with random inputs
    repeat (3) begin
      in_valid = 1'($urandom); in_sync = 1'($urandom); in_data = DATA_W'($urandom);
      @(posedge clk); #1;
    end
    check("rst.valid",   int'(sym_valid), 0);
    check("rst.data",    int'(sym_data), 0);
    check("rst.acc",     int'(sym_acc), 0);
    check("rst.overrun", int'(overrun), 0);
    check("rst.locked",  int'(locked), 0);
    rst = 1'b0; in_valid = 1'b0; in_sync = 1'b0;
    send(150, 1'b0); send(150, 1'b0); send(150, 1'b0); send(150, 1'b0); send(150, 1'b0);
    idle(1);
    check("nosync.locked", int'(locked), 0);
    check("nosync.valid",  int'(sym_valid), 0);

    // 2. Slicer, back-to-back symbols
    send_sym(150, 1'b1);
    check("lock", int'(locked), 1);
    check_sym("sl600", 600, 3);
    send_sym(50, 1'b0);    check_sym("sl200", 200, 2);
    send_sym(-100, 1'b0);  check_sym("sl-400", -400, 1);
    send_sym(-101, 1'b0);  check_sym("sl-404", -404, 0);
    send_sym(100, 1'b0);   check_sym("sl400", 400, 3);
    idle(1);
    check("sl.drain", int'(sym_valid), 0);

    // 3. Gaps between samples
    base = n_acc;
    send(150, 1'b1); idle(1);
    send(150, 1'b0); idle(3);
    send(150, 1'b0); idle(5);
    check("gap.early", int'(sym_valid), 0);
    send(150, 1'b0);
    check_sym("gap", 600, 3);
    idle(3);
    check("gap.count", n_acc - base, 1);

    // 4. Backpressure and overrun
    sym_ready = 1'b0;
    send_sym(150, 1'b0);
    check_sym("bp1", 600, 3);
    check("bp1.overrun", int'(overrun), 0);
    send_sym(-150, 1'b0);
    check_sym("bp2", 600, 3);
    check("bp2.overrun", int'(overrun), 1);
    base = n_acc;
    sym_ready = 1'b1;
    idle(1);
    check("bp.drain", int'(sym_valid), 0);
    check("bp.count", n_acc - base, 1);
    idle(2);
    check("bp.count2", n_acc - base, 1);
    check("bp.sticky", int'(overrun), 1);

    // 5. Realignment discards partial sum
    send(1000, 1'b0); send(1000, 1'b0);
    send_sym(-150, 1'b1);
    check_sym("realign", -600, 0);

    // 6. Large values, then reset mid-symbol
    send_sym(32767, 1'b0);
    check_sym("big", 131068, 3);
    send(100, 1'b0); send(100, 1'b0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    base = n_acc;
    check("mid.locked",  int'(locked), 0);
    check("mid.valid",   int'(sym_valid), 0);
    check("mid.overrun", int'(overrun), 0);
    send(100, 1'b0); send(100, 1'b0); send(100, 1'b0); send(100, 1'b0);
    idle(2);
    check("mid.count",  n_acc - base, 0);
    check("mid.locked2", int'(locked), 0);
    send_sym(50, 1'b1);
    check_sym("resume", 200, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
